// File: rtl/fifo_ctrl_pkg.sv
// fifo_ctrl_pkg: shared defaults for the fifo controller and its memory-side tops
package fifo_ctrl_pkg;
  localparam int DEF_ADDR_SIZE = 4;
  localparam int DEF_DATA_SIZE = 8;
  localparam int DEF_AF_LEVEL = 14;
  localparam int DEF_AE_LEVEL = 2;
endpackage

// File: rtl/fifo_ctrl_if.sv
// fifo_ctrl_if: request/status bundle between a fifo user and the controller
interface fifo_ctrl_if import fifo_ctrl_pkg::*; #(parameter int ADDR_SIZE = DEF_ADDR_SIZE);
  logic push, pop, flush;
  logic [ADDR_SIZE-1:0] write_addr, read_addr;
  logic write_clk_en, write_full, read_empty;
  logic [ADDR_SIZE:0] count;
  logic almost_full, almost_empty, overflow, underflow;
  modport master (
    output push, pop, flush,
    input write_addr, read_addr, write_clk_en, write_full, read_empty, count,
    input almost_full, almost_empty, overflow, underflow
  );
  modport slave (
    input push, pop, flush,
    output write_addr, read_addr, write_clk_en, write_full, read_empty, count,
    output almost_full, almost_empty, overflow, underflow
  );
endinterface

// File: rtl/fifo_ctrl_ptr.sv
// fifo_ctrl_ptr: binary wrap-around pointer with enable and synchronous clear
module fifo_ctrl_ptr import fifo_ctrl_pkg::*; #(
  parameter int W = DEF_ADDR_SIZE + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         flush,
  output logic [W-1:0] ptr
);
  // advance on enable, clear on flush; wraps modulo 2**W
  always_ff @(posedge clk or posedge rst)
    if (rst) ptr <= '0;
    else if (flush) ptr <= '0;
    else if (en) ptr <= ptr + 1'b1;
endmodule

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer, occupancy and status sequencer for a first-word-fall-through fifo
module fifo_ctrl import fifo_ctrl_pkg::*; #(
  parameter int ADDR_SIZE = DEF_ADDR_SIZE,
  parameter int AF_LEVEL = DEF_AF_LEVEL,
  parameter int AE_LEVEL = DEF_AE_LEVEL
) (
  input logic clk,
  input logic rst,
  fifo_ctrl_if.slave bus
);
  logic [ADDR_SIZE:0] wptr, rptr, wptr_n, rptr_n, count_n;
  logic acc_push, acc_pop;
  // requests are judged on the registered flags; flush masks both
  always_comb begin
    acc_push = bus.push & ~bus.write_full & ~bus.flush;
    acc_pop = bus.pop & ~bus.read_empty & ~bus.flush;
    wptr_n = bus.flush ? '0 : wptr + {{ADDR_SIZE{1'b0}}, acc_push};
    rptr_n = bus.flush ? '0 : rptr + {{ADDR_SIZE{1'b0}}, acc_pop};
    count_n = bus.flush ? '0 : bus.count + {{ADDR_SIZE{1'b0}}, acc_push} - {{ADDR_SIZE{1'b0}}, acc_pop};
  end
  fifo_ctrl_ptr #(.W(ADDR_SIZE + 1)) u_wptr (
    .clk(clk), .rst(rst), .en(acc_push), .flush(bus.flush), .ptr(wptr)
  );
  fifo_ctrl_ptr #(.W(ADDR_SIZE + 1)) u_rptr (
    .clk(clk), .rst(rst), .en(acc_pop), .flush(bus.flush), .ptr(rptr)
  );
  assign bus.write_addr = wptr[ADDR_SIZE-1:0];
  assign bus.read_addr = rptr[ADDR_SIZE-1:0];
  assign bus.write_clk_en = acc_push;
  // status registered from next-state values so no request reaches them combinationally
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bus.count <= '0;
      bus.write_full <= 1'b0;
      bus.read_empty <= 1'b1;
      bus.almost_full <= 1'b0;
      bus.almost_empty <= 1'b1;
    end else begin
      bus.count <= count_n;
      bus.write_full <= (wptr_n[ADDR_SIZE] != rptr_n[ADDR_SIZE]) &&
                        (wptr_n[ADDR_SIZE-1:0] == rptr_n[ADDR_SIZE-1:0]);
      bus.read_empty <= wptr_n == rptr_n;
      bus.almost_full <= count_n >= (ADDR_SIZE + 1)'(AF_LEVEL);
      bus.almost_empty <= count_n <= (ADDR_SIZE + 1)'(AE_LEVEL);
    end
  // sticky error flags record rejected requests until flush or reset
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bus.overflow <= 1'b0;
      bus.underflow <= 1'b0;
    end else begin
      bus.overflow <= ~bus.flush & (bus.overflow | (bus.push & bus.write_full));
      bus.underflow <= ~bus.flush & (bus.underflow | (bus.pop & bus.read_empty));
    end
endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: randomized and directed checks of fifo_ctrl against a queue model
module tb_fifo_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] din = '0;
  logic [7:0] mem [16];
  logic [7:0] q [$];
  logic m_ovf = 1'b0, m_unf = 1'b0;
  int checks = 0, errors = 0;
  fifo_ctrl_if #(.ADDR_SIZE(4)) bus ();
  fifo_ctrl #(.ADDR_SIZE(4), .AF_LEVEL(14), .AE_LEVEL(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) if (bus.write_clk_en) mem[bus.write_addr] <= din;
  wire [7:0] rdata = mem[bus.read_addr];
  wire [10:0] status = {bus.count, bus.write_full, bus.read_empty, bus.almost_full,
                        bus.almost_empty, bus.overflow, bus.underflow};
  function automatic logic [10:0] exp_status();
    int n = q.size();
    return {5'(n), n == 16, n == 0, n >= 14, n <= 2, m_ovf, m_unf};
  endfunction
  task automatic drive(input logic p, input logic po, input logic f, input logic [7:0] d);
    bus.push = p; bus.pop = po; bus.flush = f; din = d;
    @(posedge clk);
    if (f) begin
      q.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    end else begin
      bit full = q.size() == 16;
      bit empty = q.size() == 0;
      if (po && empty) m_unf = 1'b1;
      if (p && full) m_ovf = 1'b1;
      if (po && !empty) void'(q.pop_front());
      if (p && !full) q.push_back(d);
    end
    #1;
    bus.push = 1'b0; bus.pop = 1'b0; bus.flush = 1'b0;
  endtask
  task automatic test_reset();
    @(posedge clk); #1 rst = 1'b0;
    checks++; if (status !== 11'b00000_0_1_0_1_0_0) begin errors++; $display("FAIL reset_init got %b exp %b", status, 11'b00000_0_1_0_1_0_0); end
    drive(0, 1, 0, 0);
    for (int i = 0; i < 6; i++) drive(1, 0, 0, 8'($urandom));
    checks++; if (status !== exp_status()) begin errors++; $display("FAIL reset_pre got %b exp %b", status, exp_status()); end
    bus.push = 1'b1; bus.pop = 1'b1;
    #2 rst = 1'b1;
    #1;
    checks++; if (status !== 11'b00000_0_1_0_1_0_0) begin errors++; $display("FAIL reset_async got %b exp %b", status, 11'b00000_0_1_0_1_0_0); end
    checks++; if (bus.write_addr !== 4'd0 || bus.read_addr !== 4'd0) begin errors++; $display("FAIL reset_ptrs got %0d/%0d exp 0/0", bus.write_addr, bus.read_addr); end
    bus.push = 1'b0; bus.pop = 1'b0;
    q.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
  endtask
  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      drive(1, 0, 0, 8'(i));
      checks++; if (bus.almost_full !== (i >= 13)) begin errors++; $display("FAIL fill_af[%0d] got %b exp %b", i, bus.almost_full, i >= 13); end
      checks++; if (bus.write_full !== (i == 15)) begin errors++; $display("FAIL fill_full[%0d] got %b exp %b", i, bus.write_full, i == 15); end
    end
    bus.push = 1'b1; #1;
    checks++; if (bus.write_clk_en !== 1'b0) begin errors++; $display("FAIL fill_wce_full got %b exp 0", bus.write_clk_en); end
    drive(1, 0, 0, 8'hAA);
    checks++; if (bus.overflow !== 1'b1 || bus.count !== 5'd16) begin errors++; $display("FAIL fill_overflow got ovf=%b cnt=%0d exp ovf=1 cnt=16", bus.overflow, bus.count); end
    for (int i = 0; i < 16; i++) begin
      checks++; if (rdata !== 8'(i)) begin errors++; $display("FAIL drain_data[%0d] got %h exp %h", i, rdata, 8'(i)); end
      drive(0, 1, 0, 0);
    end
    checks++; if (bus.read_empty !== 1'b1 || bus.count !== 5'd0) begin errors++; $display("FAIL drain_empty got e=%b cnt=%0d exp e=1 cnt=0", bus.read_empty, bus.count); end
    drive(0, 0, 1, 0);
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL fill_flush_ovf got %b exp 0", bus.overflow); end
  endtask
  task automatic test_underflow();
    logic [3:0] ra = bus.read_addr;
    drive(0, 1, 0, 0);
    checks++; if (bus.underflow !== 1'b1 || bus.count !== 5'd0 || bus.read_addr !== ra) begin
      errors++; $display("FAIL underflow got unf=%b cnt=%0d ra=%0d exp unf=1 cnt=0 ra=%0d", bus.underflow, bus.count, bus.read_addr, ra);
    end
    drive(0, 0, 1, 0);
    checks++; if (bus.underflow !== 1'b0) begin errors++; $display("FAIL underflow_flush got %b exp 0", bus.underflow); end
  endtask
  task automatic test_concurrency();
    for (int i = 0; i < 5; i++) drive(1, 0, 0, 8'($urandom));
    for (int i = 0; i < 20; i++) begin
      checks++; if (rdata !== q[0]) begin errors++; $display("FAIL conc_data[%0d] got %h exp %h", i, rdata, q[0]); end
      drive(1, 1, 0, 8'($urandom));
      checks++; if (bus.count !== 5'd5) begin errors++; $display("FAIL conc_count[%0d] got %0d exp 5", i, bus.count); end
    end
    while (q.size() < 16) drive(1, 0, 0, 8'($urandom));
    drive(1, 1, 0, 8'h55);
    checks++; if (bus.count !== 5'd15 || bus.overflow !== 1'b1) begin errors++; $display("FAIL conc_full got cnt=%0d ovf=%b exp cnt=15 ovf=1", bus.count, bus.overflow); end
    drive(0, 0, 1, 0);
    drive(1, 1, 0, 8'h66);
    checks++; if (bus.count !== 5'd1 || bus.underflow !== 1'b1) begin errors++; $display("FAIL conc_empty got cnt=%0d unf=%b exp cnt=1 unf=1", bus.count, bus.underflow); end
    checks++; if (rdata !== 8'h66) begin errors++; $display("FAIL conc_empty_data got %h exp 66", rdata); end
    drive(0, 0, 1, 0);
  endtask
  task automatic test_flush();
    for (int i = 0; i < 9; i++) drive(1, 0, 0, 8'($urandom));
    bus.push = 1'b1; bus.pop = 1'b1; bus.flush = 1'b1; #1;
    checks++; if (bus.write_clk_en !== 1'b0) begin errors++; $display("FAIL flush_wce got %b exp 0", bus.write_clk_en); end
    drive(1, 1, 1, 8'h77);
    checks++; if (bus.count !== 5'd0 || bus.read_empty !== 1'b1) begin errors++; $display("FAIL flush_count got cnt=%0d e=%b exp cnt=0 e=1", bus.count, bus.read_empty); end
  endtask
  task automatic test_random();
    int bias = 50;
    for (int c = 0; c < 10000; c++) begin
      logic p, po, f;
      logic [7:0] d;
      if (c % 400 == 0) bias = $urandom_range(15, 85);
      p = $urandom_range(0, 99) < bias;
      po = $urandom_range(0, 99) >= bias;
      f = $urandom_range(0, 299) == 0;
      d = 8'($urandom);
      bus.push = p; bus.pop = po; bus.flush = f; #1;
      checks++; if (bus.write_clk_en !== (p && !f && q.size() < 16)) begin
        errors++; $display("FAIL rand_wce[%0d] got %b exp %b", c, bus.write_clk_en, p && !f && q.size() < 16);
      end
      if (q.size() > 0) begin
        checks++; if (rdata !== q[0]) begin errors++; $display("FAIL rand_data[%0d] got %h exp %h", c, rdata, q[0]); end
      end
      drive(p, po, f, d);
      checks++; if (status !== exp_status()) begin errors++; $display("FAIL rand_status[%0d] got %b exp %b", c, status, exp_status()); end
    end
  endtask
  initial begin
    bus.push = 1'b0; bus.pop = 1'b0; bus.flush = 1'b0;
    test_reset();
    test_fill();
    test_underflow();
    test_concurrency();
    test_flush();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
